// File: rtl/fnd_src_sel.sv
// fnd_src_sel - display-source selector feeding the FND controller.
//
// Each source channel owns a holding register that captures its data slice
// on its valid strobe. One channel is shown on a registered output. The
// channel comes from a one-hot manual select, or from automatic rotation with
// a programmable dwell. Illegal manual selects are flagged. o_upd pulses
// whenever the displayed word changes, for use as a UART send trigger.
//
// Parameters : N_CH  number of channels (2..8)
//              DW    data width per channel
//              DWELL auto-rotate dwell in clk cycles (>=1)
// Ports      : clk, rst      clock, synchronous active-high reset
//              ch_data       channel i at [i*DW +: DW]
//              ch_valid      per-channel load strobe
//              sel           one-hot manual select
//              auto_en       1 = auto-rotate, 0 = manual
//              hold          freezes the dwell counter in auto mode
//              o_data        displayed word
//              o_ch          displayed channel index
//              o_blank       manual select is all-zero (o_data forced 0)
//              o_err         manual select is multi-hot
//              o_upd         one-cycle pulse when o_data changes

// Per-channel holding register.
module fnd_src_sel_hreg #(
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] dout_d, dout_q;

  always_comb begin
    dout_d = dout_q;
    if (ld) dout_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) dout_q <= '0;
    else     dout_q <= dout_d;
  end

  assign dout = dout_q;
endmodule

module fnd_src_sel #(
  parameter int N_CH  = 3,
  parameter int DW    = 24,
  parameter int DWELL = 100_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*DW-1:0]      ch_data,
  input  logic [N_CH-1:0]         ch_valid,
  input  logic [N_CH-1:0]         sel,
  input  logic                    auto_en,
  input  logic                    hold,
  output logic [DW-1:0]           o_data,
  output logic [$clog2(N_CH)-1:0] o_ch,
  output logic                    o_blank,
  output logic                    o_err,
  output logic                    o_upd
);
  localparam int CHW  = $clog2(N_CH);
  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(N_CH - 1);

  typedef enum logic {MANUAL, AUTO} state_t;

  logic [N_CH-1:0][DW-1:0] hreg;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    fnd_src_sel_hreg #(.DW(DW)) u_hreg (
      .clk  (clk),
      .rst  (rst),
      .ld   (ch_valid[g]),
      .din  (ch_data[g*DW +: DW]),
      .dout (hreg[g])
    );
  end

  state_t          state_d, state_q;
  logic [CHW-1:0]  cur_ch_d, cur_ch_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            blank_d, blank_q;
  logic            err_d, err_q;
  logic [DW-1:0]   data_d, data_q;
  logic [CHW-1:0]  ch_d, ch_q;
  logic            upd_d, upd_q;

  // Manual select decode
  logic           sel_onehot, sel_zero;
  logic [CHW-1:0] sel_idx;
  // Word currently held for cur_ch; explicit mux keeps indexing in range.
  logic [DW-1:0]  cur_word;
  // Next channel wraps modulo N_CH, not modulo 2^CHW.
  logic [CHW-1:0] next_ch;

  always_comb begin
    sel_zero   = (sel == '0);
    sel_onehot = ($countones(sel) == 1);
    sel_idx    = '0;
    for (int i = 0; i < N_CH; i++)
      if (sel[i]) sel_idx = CHW'(i);
    cur_word = '0;
    for (int i = 0; i < N_CH; i++)
      if (cur_ch_q == CHW'(i)) cur_word = hreg[i];
    next_ch = (cur_ch_q == CH_LAST) ? '0 : cur_ch_q + CHW'(1);
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    blank_d  = blank_q;
    err_d    = err_q;
    case (state_q)
      MANUAL: begin
        if (auto_en) begin
          // Entering auto keeps the current channel; dwell restarts.
          state_d = AUTO;
          cnt_d   = '0;
          blank_d = 1'b0;
          err_d   = 1'b0;
        end else if (sel_onehot) begin
          cur_ch_d = sel_idx;
          blank_d  = 1'b0;
          err_d    = 1'b0;
        end else if (sel_zero) begin
          blank_d = 1'b1;
          err_d   = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      AUTO: begin
        blank_d = 1'b0;
        err_d   = 1'b0;
        if (!auto_en) begin
          // sel only becomes effective on the edge after the fall.
          state_d = MANUAL;
        end else if (!hold) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            cur_ch_d = next_ch;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  // Output stage works from pre-edge register values, so it trails the
  // selection state by one edge.
  always_comb begin
    data_d = blank_q ? '0 : cur_word;
    ch_d   = cur_ch_q;
    upd_d  = (data_d != data_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MANUAL;
      cur_ch_q <= '0;
      cnt_q    <= '0;
      blank_q  <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      ch_q     <= '0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
      upd_q    <= upd_d;
    end
  end

  assign o_data  = data_q;
  assign o_ch    = ch_q;
  assign o_blank = blank_q;
  assign o_err   = err_q;
  assign o_upd   = upd_q;
endmodule

// File: tb/tb_fnd_src_sel.sv
// Directed bench for fnd_src_sel. Instance "a": N_CH=3, DW=24, DWELL=4.
// Instance "b": N_CH=5, DW=16, DWELL=1 (wrap and single-cycle dwell).
module tb_fnd_src_sel;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [71:0] a_data;
  logic [2:0]  a_valid, a_sel;
  logic        a_auto, a_hold;
  logic [23:0] a_odata;
  logic [1:0]  a_och;
  logic        a_blank, a_err, a_upd;

  logic [79:0] b_data;
  logic [4:0]  b_valid, b_sel;
  logic        b_auto, b_hold;
  logic [15:0] b_odata;
  logic [2:0]  b_och;
  logic        b_blank, b_err, b_upd;

  int errors = 0;
  int checks = 0;

  fnd_src_sel #(.N_CH(3), .DW(24), .DWELL(4)) u_a (
    .clk(clk), .rst(rst), .ch_data(a_data), .ch_valid(a_valid), .sel(a_sel),
    .auto_en(a_auto), .hold(a_hold), .o_data(a_odata), .o_ch(a_och),
    .o_blank(a_blank), .o_err(a_err), .o_upd(a_upd));

  fnd_src_sel #(.N_CH(5), .DW(16), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .ch_data(b_data), .ch_valid(b_valid), .sel(b_sel),
    .auto_en(b_auto), .hold(b_hold), .o_data(b_odata), .o_ch(b_och),
    .o_blank(b_blank), .o_err(b_err), .o_upd(b_upd));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_valid = '0; a_sel = '0; a_auto = 1'b0; a_hold = 1'b0;
    b_data = '0; b_valid = '0; b_sel = '0; b_auto = 1'b0; b_hold = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_data", a_odata, 0);
    chk("rst_ch", a_och, 0);
    chk("rst_blank", a_blank, 0);
    chk("rst_err", a_err, 0);
    chk("rst_upd", a_upd, 0);

    // Load ch1 and select it: o_data appears two edges later.
    a_data[24 +: 24] = 24'h000123; a_valid = 3'b010; a_sel = 3'b010;
    step();
    a_valid = '0;
    chk("lat_t0_data", a_odata, 0);
    chk("lat_t0_upd", a_upd, 0);
    step();
    chk("lat_t1_data", a_odata, 24'h000123);
    chk("lat_t1_ch", a_och, 1);
    chk("lat_t1_upd", a_upd, 1);
    step();
    chk("lat_t2_upd", a_upd, 0);

    // Multi-hot select
    a_sel = 3'b011;
    step();
    chk("mh_err", a_err, 1);
    step();
    chk("mh_ch", a_och, 1);
    chk("mh_data", a_odata, 24'h000123);
    chk("mh_upd", a_upd, 0);

    // All-zero select blanks
    a_sel = 3'b000;
    step();
    chk("z_blank", a_blank, 1);
    chk("z_err", a_err, 0);
    step();
    chk("z_data", a_odata, 0);
    chk("z_upd", a_upd, 1);
    step();
    chk("z_upd_end", a_upd, 0);

    // Blank -> non-zero fires o_upd
    a_sel = 3'b010;
    step();
    chk("unb_blank", a_blank, 0);
    step();
    chk("unb_data", a_odata, 24'h000123);
    chk("unb_upd", a_upd, 1);

    // Identical reload: no o_upd. Also load ch0 and ch2 in the same cycle.
    a_data[0 +: 24] = 24'h000111; a_data[48 +: 24] = 24'h000222;
    a_valid = 3'b111;
    step();
    a_valid = '0;
    chk("same_upd0", a_upd, 0);
    step();
    chk("same_upd1", a_upd, 0);

    // Select ch0, then auto-rotate with DWELL=4.
    a_sel = 3'b001;
    step(); step();
    chk("m0_data", a_odata, 24'h000111);
    a_auto = 1'b1;
    step(); // E0: enter AUTO
    for (int e = 1; e <= 13; e++) begin
      step();
      chk($sformatf("rot_ch_e%0d", e), a_och, (e <= 4) ? 0 : (e <= 8) ? 1 : (e <= 12) ? 2 : 0);
      if (e == 5) chk("rot_data_e5", a_odata, 24'h000123);
      if (e == 9) chk("rot_data_e9", a_odata, 24'h000222);
    end

    // Hold for 10 edges with the counter at 1: advance moves from E16 to E26.
    a_hold = 1'b1;
    repeat (10) step();
    a_hold = 1'b0;
    step(); step(); step(); // E26
    chk("hold_e26_ch", a_och, 0);
    step(); // E27
    chk("hold_e27_ch", a_och, 1);
    chk("hold_e27_upd", a_upd, 1);

    // Strobe ch2 on the same edge as rotation 1->2 (E30).
    step(); step(); // E29
    a_data[48 +: 24] = 24'hABCDEF; a_valid = 3'b100;
    step(); // E30
    a_valid = '0;
    chk("sim_e30_data", a_odata, 24'h000123);
    chk("sim_e30_upd", a_upd, 0);
    step();
    chk("sim_e31_data", a_odata, 24'hABCDEF);
    chk("sim_e31_ch", a_och, 2);
    chk("sim_e31_upd", a_upd, 1);
    step();
    chk("sim_e32_upd", a_upd, 0);

    // Reset with counter at 2; auto_en stays high so AUTO is re-entered.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_data", a_odata, 0);
    chk("mrst_ch", a_och, 0);
    chk("mrst_upd", a_upd, 0);
    chk("mrst_blank", a_blank, 0);
    chk("mrst_err", a_err, 0);
    a_data[24 +: 24] = 24'h000555; a_valid = 3'b010;
    step(); // R0: enter AUTO, ch1 loaded
    a_valid = '0;
    step(); step(); step(); step(); // R4: advance to ch1
    chk("re_r4_ch", a_och, 0);
    step();
    chk("re_r5_ch", a_och, 1);
    chk("re_r5_data", a_odata, 24'h000555);

    // auto_en fall: sel takes effect one edge later.
    a_auto = 1'b0; a_sel = 3'b100;
    step(); // fall edge, cur stays 1
    step(); // sel applied, o_ch still shows 1
    chk("fall_ch1", a_och, 1);
    step();
    chk("fall_ch2", a_och, 2);

    // Instance b: 5 channels, DWELL=1, wrap 4->0.
    for (int i = 0; i < 5; i++) b_data[i*16 +: 16] = 16'(16'h1000 + i);
    b_valid = 5'b11111; b_sel = 5'b00001;
    step(); // F0
    b_valid = '0;
    b_auto = 1'b1;
    step(); // F1: enter AUTO
    for (int k = 2; k <= 13; k++) begin
      step();
      chk($sformatf("b_ch_f%0d", k), b_och, (k - 2) % 5);
      chk($sformatf("b_data_f%0d", k), b_odata, 16'h1000 + ((k - 2) % 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
